mem_block_mover: RTL

MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

---
 rtl/mem_block_mover_pkg.sv | 14 +
 rtl/mem_block_mover.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_block_mover_pkg.sv
// Shared types and default sizing for the memory block mover.
package mem_block_mover_pkg;

    localparam int unsigned DEF_W = 8;
    localparam int unsigned DEF_A = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_block_mover.sv
// Copies Length entries from SrcAddr to DstAddr over a single-port memory, 2 cycles per entry.
// Define MEM_BLOCK_MOVER_CHECKSUM_EN to add the Checksum output (sum of written entries).
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned A = DEF_A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Length,
    output logic         Busy,
    output logic         Done,
    output logic [A-1:0] MemAddress,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataOut,
    input  logic [W-1:0] MemDataIn
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    ,
    output logic [W-1:0] Checksum
`endif
);

    localparam logic [A:0] ONE = {{A{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A:0]   rem_q, rem_d;
    logic [W-1:0] data_q, data_d;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    logic [W-1:0] cks_q, cks_d;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
                    rem_d   = Length;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
                    cks_d   = '0;
`endif
                    state_d = (Length != '0) ? READ : DONE;
                end
            end
            READ: begin
                data_d  = MemDataIn;
                state_d = WRITE;
            end
            WRITE: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
                cks_d   = cks_q + data_q;
`endif
                // Decide on the pre-decrement count: >1 means another entry is pending.
                state_d = (rem_q > ONE) ? READ : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // Every output is decoded from registers only, so Start can never glitch the write enable.
    always_comb begin
        case (state_q)
            READ:    MemAddress = src_q;
            WRITE:   MemAddress = dst_q;
            default: MemAddress = '0;
        endcase
    end

    assign Busy       = (state_q == READ) || (state_q == WRITE);
    assign Done       = (state_q == DONE);
    assign MemWriteEn = (state_q == WRITE);
    assign MemDataOut = data_q;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    assign Checksum   = cks_q;
`endif

endmodule
